// File: rtl/geri_yaz_birimi.sv
// geri_yaz_birimi: registered writeback stage feeding the single register-file
// write port toward COZ.
//   - The in-order YURUT slot always has priority.
//   - UZUN_SAYISI long-latency channels (divider, FPU, ...) are granted
//     round-robin in cycles where YURUT does not write a register.
//   - A saturating counter counts cycles in which a long-latency result was
//     pending but the slot was taken by YURUT.
// Ports:
//   clk_i, rstn_i             clock (rising edge), async active-low reset
//   yrt_*                     YURUT slot: valid, writes-rd, source select,
//                             rd address, ALU / multiplier / PC+ values
//   uzun_gecerli_i            per-channel result valid
//   uzun_hazir_o              per-channel accept (combinational)
//   uzun_rd_adres_i           packed 5-bit addresses, channel k at [5k+4:5k]
//   uzun_deger_i              packed data, channel k at [VERI_BIT*k +: VERI_BIT]
//   cyo_yaz_adres_o           registered write address
//   cyo_yaz_deger_o           registered write data
//   cyo_yaz_yazmac_o          registered write enable
//   cakisma_sayisi_o          saturating blocked-cycle count
module geri_yaz_birimi #(
  parameter int VERI_BIT    = 32,
  parameter int UZUN_SAYISI = 2,
  parameter int SAYAC_BIT   = 16
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            yrt_gecerli_i,
  input  logic                            yrt_yazmac_i,
  input  logic [1:0]                      yrt_kaynak_i,
  input  logic [4:0]                      yrt_rd_adres_i,
  input  logic [VERI_BIT-1:0]             yrt_rd_deger_i,
  input  logic [VERI_BIT-1:0]             yrt_carpma_deger_i,
  input  logic [VERI_BIT-2:0]             yrt_ps_artmis_i,
  input  logic [UZUN_SAYISI-1:0]          uzun_gecerli_i,
  output logic [UZUN_SAYISI-1:0]          uzun_hazir_o,
  input  logic [5*UZUN_SAYISI-1:0]        uzun_rd_adres_i,
  input  logic [VERI_BIT*UZUN_SAYISI-1:0] uzun_deger_i,
  output logic [4:0]                      cyo_yaz_adres_o,
  output logic [VERI_BIT-1:0]             cyo_yaz_deger_o,
  output logic                            cyo_yaz_yazmac_o,
  output logic [SAYAC_BIT-1:0]            cakisma_sayisi_o
);

  // A single channel still needs a one-bit pointer to keep the vectors legal.
  localparam int SIRA_BIT = (UZUN_SAYISI > 1) ? $clog2(UZUN_SAYISI) : 1;
  localparam logic [UZUN_SAYISI-1:0] TEK_BIT    = UZUN_SAYISI'(1);
  localparam logic [SAYAC_BIT-1:0]   SAYAC_MAKS = {SAYAC_BIT{1'b1}};

  logic                   ana_yaz_s;
  logic [VERI_BIT-1:0]    ana_deger_s;
  logic                   kazanan_var_s;
  logic [SIRA_BIT-1:0]    kazanan_s;
  logic [UZUN_SAYISI-1:0] hazir_s;
  logic [4:0]             uzun_adres_s;
  logic [VERI_BIT-1:0]    uzun_deger_s;

  logic [SIRA_BIT-1:0]    sira_d, sira_q;
  logic [4:0]             adres_d, adres_q;
  logic [VERI_BIT-1:0]    deger_d, deger_q;
  logic                   yazmac_d, yazmac_q;
  logic [SAYAC_BIT-1:0]   sayac_d, sayac_q;

  // YURUT write request and value selection.
  always_comb begin
    ana_yaz_s = yrt_gecerli_i & yrt_yazmac_i & (yrt_kaynak_i != 2'b11) &
                (yrt_rd_adres_i != 5'd0);
    case (yrt_kaynak_i)
      2'b00:   ana_deger_s = yrt_rd_deger_i;
      2'b01:   ana_deger_s = {yrt_ps_artmis_i, 1'b0};
      2'b10:   ana_deger_s = yrt_carpma_deger_i;
      default: ana_deger_s = '0;
    endcase
  end

  // Round-robin search: first valid channel at or after the pointer.
  // Only valids and the pointer feed the grant, never channel data/address.
  always_comb begin
    int idx;
    idx           = 0;
    kazanan_var_s = 1'b0;
    kazanan_s     = '0;
    for (int i = 0; i < UZUN_SAYISI; i++) begin
      idx = (int'(sira_q) + i) % UZUN_SAYISI;
      if (!kazanan_var_s && uzun_gecerli_i[idx[SIRA_BIT-1:0]]) begin
        kazanan_var_s = 1'b1;
        kazanan_s     = idx[SIRA_BIT-1:0];
      end else begin
        kazanan_var_s = kazanan_var_s;
      end
    end
    if (kazanan_var_s && !ana_yaz_s) begin
      hazir_s = TEK_BIT << kazanan_s;
    end else begin
      hazir_s = '0;
    end
  end

  // Accept is forced low while reset is asserted.
  assign uzun_hazir_o = hazir_s & {UZUN_SAYISI{rstn_i}};

  // Extract the granted channel's address and data.
  always_comb begin
    uzun_adres_s = 5'd0;
    uzun_deger_s = '0;
    for (int k = 0; k < UZUN_SAYISI; k++) begin
      if (kazanan_s == SIRA_BIT'(k)) begin
        uzun_adres_s = uzun_rd_adres_i[5*k +: 5];
        uzun_deger_s = uzun_deger_i[VERI_BIT*k +: VERI_BIT];
      end else begin
        uzun_adres_s = uzun_adres_s;
      end
    end
  end

  // Next-state for output register, pointer and blocked-cycle counter.
  always_comb begin
    int sonraki;
    sonraki  = (int'(kazanan_s) + 1) % UZUN_SAYISI;
    sira_d   = sira_q;
    adres_d  = adres_q;
    deger_d  = deger_q;
    yazmac_d = 1'b0;
    sayac_d  = sayac_q;
    if (ana_yaz_s) begin
      adres_d  = yrt_rd_adres_i;
      deger_d  = ana_deger_s;
      yazmac_d = 1'b1;
    end else if (kazanan_var_s) begin
      // x0 results complete the handshake but never write the register file.
      adres_d  = uzun_adres_s;
      deger_d  = uzun_deger_s;
      yazmac_d = (uzun_adres_s != 5'd0);
      sira_d   = sonraki[SIRA_BIT-1:0];
    end else begin
      yazmac_d = 1'b0;
    end
    // A pending channel without a transfer can only mean YURUT held the slot.
    if ((|uzun_gecerli_i) && ana_yaz_s && (sayac_q != SAYAC_MAKS)) begin
      sayac_d = sayac_q + SAYAC_BIT'(1);
    end else begin
      sayac_d = sayac_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sira_q   <= '0;
      adres_q  <= 5'd0;
      deger_q  <= '0;
      yazmac_q <= 1'b0;
      sayac_q  <= '0;
    end else begin
      sira_q   <= sira_d;
      adres_q  <= adres_d;
      deger_q  <= deger_d;
      yazmac_q <= yazmac_d;
      sayac_q  <= sayac_d;
    end
  end

  assign cyo_yaz_adres_o  = adres_q;
  assign cyo_yaz_deger_o  = deger_q;
  assign cyo_yaz_yazmac_o = yazmac_q;
  assign cakisma_sayisi_o = sayac_q;

endmodule
